fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 110 +++++++++++
 tb/tb_fifo_uart_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls payload words from an upstream show-ahead FIFO.
// Sends a frame of one start bit, DATA_WIDTH data bits (LSB first) and one stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  tx_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  baud_wrap;

  // The pop is combinational so the head word is captured in the same cycle it is acknowledged.
  assign fifo_rd_en = !rst && (state == IDLE) && tx_en && !fifo_empty;
  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign shift_next = shift >> 1;

  // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shift    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          if (fifo_rd_en) begin
            shift <= fifo_rd_data;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            shift    <= shift_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            // Registered pulse: raise it one edge early so it is visible on the final stop cycle.
            if (baud_cnt == BAUD_PRE) tx_done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: directed scenarios plus random traffic, checked every cycle
// against a frame-level model of the serial line driven from a queue-based FIFO.
module tb_fifo_uart_tx;

  localparam int DW        = 8;
  localparam int CPB       = 4;
  localparam int FRAME_LEN = (DW + 2) * CPB;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          tx_en;
  logic          tx;
  logic          busy;
  logic          tx_done;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx_en       (tx_en),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: upstream FIFO contents and the frame currently on the line.
  logic [DW-1:0] fq[$];
  int            remaining = 0;
  logic [DW+1:0] frame_bits = '1;
  int            cyc = 0;
  int            obs_pops = 0;
  int            obs_done = 0;
  int            last_pop_cyc = -1;
  int            prev_pop_cyc = -1;
  logic          prev_done = 1'b0;
  logic          prev_busy = 1'b0;
  logic          prev_rst  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: present FIFO view, compare outputs to the model, advance the model.
  task automatic run_cycle();
    logic          exp_tx, exp_busy, exp_done, exp_pop;
    logic [DW-1:0] word;
    int            p;
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : DW'($urandom);
    #1;
    if (remaining > 0) begin
      p        = FRAME_LEN - remaining;
      exp_tx   = frame_bits[p / CPB];
      exp_busy = 1'b1;
      exp_done = (remaining == 1);
      exp_pop  = 1'b0;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_pop  = !rst && tx_en && (fq.size() != 0);
    end
    check("tx", 32'(tx), 32'(exp_tx));
    check("busy", 32'(busy), 32'(exp_busy));
    check("tx_done", 32'(tx_done), 32'(exp_done));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_pop));
    if (fifo_rd_en) check("rd_en_while_empty", 32'(fifo_empty), 32'(0));
    if (prev_done) check("tx_done_consecutive", 32'(tx_done), 32'(0));
    if (prev_busy && !busy) check("busy_fall_cause", 32'(prev_done || prev_rst), 32'(1));

    if (fifo_rd_en === 1'b1) begin
      obs_pops++;
      prev_pop_cyc = last_pop_cyc;
      last_pop_cyc = cyc;
    end
    if (tx_done === 1'b1) obs_done++;

    if (remaining > 0) begin
      remaining--;
    end else if (exp_pop) begin
      word       = fq.pop_front();
      frame_bits = {1'b1, word, 1'b0};
      remaining  = FRAME_LEN;
    end
    if (rst) remaining = 0;
    prev_done = tx_done;
    prev_busy = busy;
    prev_rst  = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    int pops0, done0, guard;
    rst          = 1'b1;
    tx_en        = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    @(posedge clk);
    #1;

    // Reset state, including a request that must be ignored while rst is high.
    fq.push_back(8'h11);
    tx_en = 1'b1;
    run_n(3);
    fq.delete();
    rst   = 1'b0;
    tx_en = 1'b0;
    run_n(2);

    // Single frame of 0xA5.
    pops0 = obs_pops;
    done0 = obs_done;
    fq.push_back(8'hA5);
    tx_en = 1'b1;
    run_n(FRAME_LEN + 5);
    check("a5_pop_count", 32'(obs_pops - pops0), 32'(1));
    check("a5_done_count", 32'(obs_done - done0), 32'(1));

    // Back-to-back 0x00 then 0xFF.
    pops0 = obs_pops;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    run_n(2 * FRAME_LEN + 10);
    check("b2b_pop_count", 32'(obs_pops - pops0), 32'(2));
    check("b2b_pop_spacing", 32'(last_pop_cyc - prev_pop_cyc), 32'(FRAME_LEN + 1));

    // Gated start: word waits while tx_en is low.
    pops0 = obs_pops;
    tx_en = 1'b0;
    fq.push_back(8'h3C);
    run_n(20);
    check("gated_no_pop", 32'(obs_pops - pops0), 32'(0));
    tx_en = 1'b1;
    run_n(1);
    check("gated_pop_first_cycle", 32'(obs_pops - pops0), 32'(1));
    run_n(FRAME_LEN + 2);

    // Empty FIFO with tx_en held high.
    pops0 = obs_pops;
    run_n(100);
    check("empty_no_pop", 32'(obs_pops - pops0), 32'(0));

    // Reset during data bit 3 of 0x5A; the word must not be resent or completed.
    pops0 = obs_pops;
    done0 = obs_done;
    fq.push_back(8'h5A);
    guard = 0;
    while (remaining != FRAME_LEN - 4 * CPB && guard < 100) begin
      run_cycle();
      guard++;
    end
    check("reach_data_bit3", 32'(guard < 100), 32'(1));
    rst = 1'b1;
    run_n(1);
    rst = 1'b0;
    run_n(FRAME_LEN + 5);
    check("abort_pop_count", 32'(obs_pops - pops0), 32'(1));
    check("abort_no_done", 32'(obs_done - done0), 32'(0));

    // Random traffic: sporadic pushes, tx_en toggling and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      tx_en = ($urandom_range(0, 3) != 0);
      if (fq.size() < 4 && $urandom_range(0, 24) == 0) fq.push_back(DW'($urandom));
      run_cycle();
    end
    rst   = 1'b0;
    tx_en = 1'b1;
    run_n(5 * FRAME_LEN);
    check("random_drained", 32'(fq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
